// File: rtl/keypad_scan.sv
// Row-scanned 4x4 keypad decoder with frame-level debounce.
// Rows are driven active-low one at a time and advance on each scan_tick.
// A frame is the four ticks covering rows 0..3. A frame resolves to a single
// key code only when exactly one switch is closed during that frame.
// The debounce FSM runs only on frame-end ticks.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | no key accepted, waiting for a single-key frame
//   PRESS_DB   | counting consecutive frames that show candidate key cand
//   HELD       | cand accepted, key_pressed high, watching for release
//   RELEASE_DB | counting consecutive empty frames before dropping key_pressed
module keypad_scan #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_tick,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0] DB = 4'(DEBOUNCE);

    // Frame accumulator. acc_n saturates at 2, which stands for "two or more".
    logic [1:0] acc_n;
    logic [3:0] acc_code;

    logic [1:0] row_idx;
    logic [1:0] col_idx;
    logic [2:0] pop;
    logic [2:0] tot;
    logic [1:0] merged_n;
    logic [3:0] merged_code;
    logic       frame_end;
    logic       res_key;

    state_t     state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    logic [3:0] cand_q, cand_n;
    logic [3:0] code_q, code_n;
    logic       valid_q, valid_n;
    logic       pressed_q, pressed_n;
    logic [3:0] cnt_inc;

    // Merge the current row's column sample into the running frame summary.
    always_comb begin
        row_idx = 2'd0;
        case (row)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        pop     = 3'd0;
        col_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col[i]) begin
                pop     = pop + 3'd1;
                col_idx = 2'(i);
            end
        end
        tot         = {1'b0, acc_n} + pop;
        merged_n    = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        merged_code = (acc_n == 2'd1) ? acc_code : {row_idx, col_idx};
    end

    assign frame_end = scan_tick && (row == 4'b0111);
    assign res_key   = (merged_n == 2'd1);

    // Row rotation and per-frame accumulator; the accumulator clears at frame end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row      <= 4'b1110;
            acc_n    <= 2'd0;
            acc_code <= 4'd0;
        end else if (scan_tick) begin
            row <= {row[2:0], row[3]};
            if (frame_end) begin
                acc_n    <= 2'd0;
                acc_code <= 4'd0;
            end else begin
                acc_n    <= merged_n;
                acc_code <= merged_code;
            end
        end
    end

    // Debounce FSM state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            cand_q    <= 4'd0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            cand_q    <= cand_n;
            code_q    <= code_n;
            valid_q   <= valid_n;
            pressed_q <= pressed_n;
        end
    end

    // Next-state decision, evaluated only on the frame-end tick.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        cand_n    = cand_q;
        code_n    = code_q;
        valid_n   = 1'b0;
        pressed_n = pressed_q;
        cnt_inc   = (cnt_q >= DB) ? DB : cnt_q + 4'd1;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (res_key) begin
                        cand_n = merged_code;
                        if (DB <= 4'd1) begin
                            state_n   = HELD;
                            cnt_n     = 4'd0;
                            code_n    = merged_code;
                            valid_n   = 1'b1;
                            pressed_n = 1'b1;
                        end else begin
                            state_n = PRESS_DB;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                PRESS_DB: begin
                    if (res_key && merged_code == cand_q) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB) begin
                            state_n   = HELD;
                            cnt_n     = 4'd0;
                            code_n    = cand_q;
                            valid_n   = 1'b1;
                            pressed_n = 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                HELD: begin
                    if (!(res_key && merged_code == cand_q)) begin
                        if (!res_key && DB <= 4'd1) begin
                            // A single empty frame is already a full release.
                            state_n   = IDLE;
                            cnt_n     = 4'd0;
                            pressed_n = 1'b0;
                        end else begin
                            state_n = RELEASE_DB;
                            cnt_n   = res_key ? 4'd0 : 4'd1;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (res_key && merged_code == cand_q) begin
                        state_n = HELD;
                        cnt_n   = 4'd0;
                    end else if (res_key) begin
                        cnt_n = 4'd0;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DB) begin
                            state_n   = IDLE;
                            cnt_n     = 4'd0;
                            pressed_n = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_pressed = pressed_q;

endmodule
